// File: rtl/heat_sync_ctrl.sv
// rtl/heat_sync_ctrl.sv - global iteration sequencer and snapshot streamer for the build_column array
// Collects per-column done flags, issues the shared start pulse and streams node_center snapshots.
module heat_sync_ctrl #(
  parameter int NUM_COLS       = 32,
  parameter int ITER_PER_FRAME = 16,
  parameter int TIMEOUT        = 4096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [NUM_COLS-1:0]     col_initflag,
  input  logic [NUM_COLS-1:0]     col_flag,
  input  logic [32*NUM_COLS-1:0]  col_node_center,
  output logic                    start,
  output logic [15:0]             iter_count,
  output logic                    snap_valid,
  input  logic                    snap_ready,
  output logic [7:0]              snap_col,
  output logic [31:0]             snap_data,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int              TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_MAX = TW'(TIMEOUT - 1);
  localparam logic [15:0]     FRAME_LEN = 16'(ITER_PER_FRAME);
  localparam logic [7:0]      LAST_COL  = 8'(NUM_COLS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_INIT,
    S_WAIT_DONE,
    S_SNAPSHOT,
    S_RELEASE,
    S_WAIT_CLEAR,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [15:0]     iter_q, iter_d;
  logic            start_q, start_d;
  logic            snap_valid_q, snap_valid_d;
  logic [7:0]      snap_col_q, snap_col_d;
  logic [31:0]     snap_data_q, snap_data_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            all_init, all_done, any_done;
  logic            timed, expired, frame_hit;
  logic [15:0]     iter_inc;
  logic [7:0]      next_col;
  logic [31:0]     node_sel;

  assign all_init  = &col_initflag;
  assign all_done  = &col_flag;
  assign any_done  = |col_flag;
  assign timed     = (state_q == S_WAIT_INIT) || (state_q == S_WAIT_DONE) ||
                     (state_q == S_WAIT_CLEAR);
  assign expired   = timed && (timer_q == TIMER_MAX);
  assign iter_inc  = iter_q + 16'd1;
  assign frame_hit = (iter_inc % FRAME_LEN) == 16'd0;
  assign next_col  = snap_col_q + 8'd1;

  // Constant-index mux keeps the slice select free of variable part-selects.
  always_comb begin
    node_sel = '0;
    for (int i = 0; i < NUM_COLS; i++) begin
      if (next_col == 8'(i)) node_sel = col_node_center[32*i +: 32];
    end
  end

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    start_d      = 1'b0;
    snap_valid_d = snap_valid_q;
    snap_col_d   = snap_col_q;
    snap_data_d  = snap_data_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (run) state_d = (all_init && all_done) ? S_RELEASE : S_WAIT_INIT;
      end
      S_WAIT_INIT: begin
        if (all_init)     state_d = S_WAIT_DONE;
        else if (expired) state_d = S_ERROR;
      end
      S_WAIT_DONE: begin
        if (all_done) begin
          iter_d = iter_inc;
          if (frame_hit) begin
            state_d      = S_SNAPSHOT;
            snap_valid_d = 1'b1;
            snap_col_d   = 8'd0;
            snap_data_d  = col_node_center[31:0];
          end else begin
            state_d = S_RELEASE;
          end
        end else if (expired) begin
          state_d = S_ERROR;
        end
      end
      S_SNAPSHOT: begin
        if (snap_ready) begin
          if (snap_col_q == LAST_COL) begin
            state_d      = S_RELEASE;
            snap_valid_d = 1'b0;
            snap_col_d   = 8'd0;
          end else begin
            snap_col_d  = next_col;
            snap_data_d = node_sel;
          end
        end
      end
      S_RELEASE: begin
        if (run) begin
          start_d = 1'b1;
          state_d = S_WAIT_CLEAR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_CLEAR: begin
        // Leaving only on all-low flags keeps last iteration's done flags from counting twice.
        if (!any_done)    state_d = S_WAIT_DONE;
        else if (expired) state_d = S_ERROR;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ERROR) err_d = 1'b1;
    busy_d = !((state_d == S_IDLE) || (state_d == S_ERROR));

    if (state_d != state_q) timer_d = '0;
    else if (timed)         timer_d = timer_q + 1'b1;
    else                    timer_d = timer_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      iter_q       <= '0;
      start_q      <= 1'b0;
      snap_valid_q <= 1'b0;
      snap_col_q   <= '0;
      snap_data_q  <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      iter_q       <= iter_d;
      start_q      <= start_d;
      snap_valid_q <= snap_valid_d;
      snap_col_q   <= snap_col_d;
      snap_data_q  <= snap_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign start       = start_q;
  assign iter_count  = iter_q;
  assign snap_valid  = snap_valid_q;
  assign snap_col    = snap_col_q;
  assign snap_data   = snap_data_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule
